// File: rtl/matrix_scan_driver_if.sv
// rtl/matrix_scan_driver_if.sv - frame inputs and serial/row scan outputs of matrix_scan_driver
interface matrix_scan_driver_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic                 en;
  logic                 blink_en;
  logic [ROWS*COLS-1:0] red;
  logic [ROWS*COLS-1:0] blue;
  logic                 oe;
  logic                 SH_CP;
  logic                 ST_CP;
  logic                 sr_clr_n;
  logic                 DS;
  logic [ROWS-1:0]      CAT;
  logic                 frame_done;
  logic                 busy;

  modport master (
    output en, blink_en, red, blue,
    input  oe, SH_CP, ST_CP, sr_clr_n, DS, CAT, frame_done, busy
  );

  modport slave (
    input  en, blink_en, red, blue,
    output oe, SH_CP, ST_CP, sr_clr_n, DS, CAT, frame_done, busy
  );
endinterface

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - two-colour LED matrix scanner driving 74HC595-style column chains
// and one-hot cathode rows, with frame-level shadowing and blink blanking.
module matrix_scan_driver #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DIV          = 1,
  parameter int HOLD         = 64,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  CLK,
  input  logic                  res,
  matrix_scan_driver_if.slave   bus
);

  localparam int TMAX = (DIV > HOLD) ? DIV : HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(2 * COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int FW   = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_DISPLAY
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_tmr;
  logic [BW-1:0]     r_bit;
  logic [RW-1:0]     r_row;
  logic [FW-1:0]     r_fcnt;
  logic              r_phase;
  logic              r_frame_done;
  logic [COLS-1:0]   r_red_sh  [ROWS];
  logic [COLS-1:0]   r_blue_sh [ROWS];

  state_t            w_state_nxt;
  logic [TW-1:0]     w_tmr_lim;
  logic              w_tmr_done;
  logic              w_bit_last;
  logic              w_row_last;
  logic              w_frame_end;
  logic [2*COLS-1:0] w_seq;
  logic [COLS-1:0]   w_row_red;
  logic [COLS-1:0]   w_row_blue;

  // Current row laid out in shift order: blue MSB..LSB, then red MSB..LSB.
  always_comb begin
    w_row_red  = r_red_sh[r_row];
    w_row_blue = r_blue_sh[r_row];
    w_seq      = '0;
    for (int j = 0; j < COLS; j++) begin
      w_seq[j]        = w_row_blue[COLS-1-j];
      w_seq[COLS + j] = w_row_red[COLS-1-j];
    end
  end

  always_comb begin
    w_tmr_lim   = (r_state == S_DISPLAY) ? TW'(HOLD - 1) : TW'(DIV - 1);
    w_tmr_done  = (r_tmr == w_tmr_lim);
    w_bit_last  = (r_bit == BW'(2 * COLS - 1));
    w_row_last  = (r_row == RW'(ROWS - 1));
    w_frame_end = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.en) w_state_nxt = S_SNAP;
      S_SNAP:     w_state_nxt = S_SHIFT_LO;
      S_SHIFT_LO: if (w_tmr_done) w_state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: if (w_tmr_done) w_state_nxt = w_bit_last ? S_LATCH : S_SHIFT_LO;
      S_LATCH:    if (w_tmr_done) w_state_nxt = S_DISPLAY;
      S_DISPLAY: begin
        if (w_tmr_done) begin
          if (w_row_last) begin
            w_frame_end = 1'b1;
            w_state_nxt = bus.en ? S_SNAP : S_IDLE;
          end else begin
            w_state_nxt = S_SHIFT_LO;
          end
        end
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.oe       = 1'b1;
    bus.CAT      = '0;
    bus.SH_CP    = 1'b0;
    bus.ST_CP    = 1'b0;
    bus.DS       = 1'b0;
    bus.sr_clr_n = (r_state != S_IDLE);
    bus.busy     = (r_state != S_IDLE);
    case (r_state)
      S_SHIFT_LO: bus.DS = w_seq[r_bit];
      S_SHIFT_HI: begin
        bus.DS    = w_seq[r_bit];
        bus.SH_CP = 1'b1;
      end
      S_LATCH:    bus.ST_CP = 1'b1;
      S_DISPLAY: begin
        bus.CAT = ROWS'(1) << r_row;
        bus.oe  = bus.blink_en & r_phase;
      end
      default:    ;
    endcase
  end

  assign bus.frame_done = r_frame_done;

  always_ff @(posedge CLK) begin
    if (res) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      r_bit        <= '0;
      r_row        <= '0;
      r_fcnt       <= '0;
      r_phase      <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        r_red_sh[i]  <= '0;
        r_blue_sh[i] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame_end;

      if (w_state_nxt != r_state || r_state == S_IDLE || r_state == S_SNAP)
        r_tmr <= '0;
      else
        r_tmr <= r_tmr + TW'(1);

      if (r_state == S_SNAP) begin
        r_row <= '0;
        r_bit <= '0;
        for (int i = 0; i < ROWS; i++) begin
          r_red_sh[i]  <= bus.red[i*COLS +: COLS];
          r_blue_sh[i] <= bus.blue[i*COLS +: COLS];
        end
      end else if (r_state == S_SHIFT_HI && w_tmr_done && !w_bit_last) begin
        r_bit <= r_bit + BW'(1);
      end else if (r_state == S_DISPLAY && w_tmr_done && !w_row_last) begin
        r_row <= r_row + RW'(1);
        r_bit <= '0;
      end

      // Blink phase flips every BLINK_FRAMES completed frames.
      if (!bus.blink_en) begin
        r_fcnt  <= '0;
        r_phase <= 1'b0;
      end else if (w_frame_end) begin
        if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end
    end
  end

endmodule
